// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO register offsets,
// STATUS bit positions and the TX FIFO geometry.
package dmem_pkg;

  // Word offset inside the 16-byte MMIO window (maddr[3:2]).
  typedef enum logic [1:0] {
    OFF_LED    = 2'd0,
    OFF_CYCLE  = 2'd1,
    OFF_TXDATA = 2'd2,
    OFF_STATUS = 2'd3
  } mmio_off_e;

  // STATUS register layout.
  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_ERR     = 3;
  localparam int STAT_CNT_LSB = 4;

  localparam int TX_DEPTH = 4;
  localparam int TX_CNT_W = $clog2(TX_DEPTH + 1);

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO feeding the byte TX port.
// Ports: clk/reset (sync, active-high); push_i/wdata_i enqueue; pop_i dequeue
// (ignored when empty); rdata_o head entry (0 when empty); full_o, empty_o,
// count_o occupancy 0..DEPTH.
// A push while full is accepted only if a pop happens in the same cycle.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  // Forced to 0 when empty so the idle port never shows stale bytes.
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined CPU's memory stage.
// Ports: clk/reset (sync, active-high); DM_CS_M/DM_R_M/DM_W_M request
// strobes; maddr byte address; mwdata write data; mr_data_M zero-latency read
// data; led_out LED register; tx_data/tx_valid/tx_ready byte TX stream.
// Holds the word RAM, the MMIO decode, LED register, cycle counter and the
// sticky ovf/err flags; the TX queue lives in tx_fifo.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DM_CS_M,
  input  logic        DM_R_M,
  input  logic        DM_W_M,
  input  logic [31:0] maddr,
  input  logic [31:0] mwdata,
  output logic [31:0] mr_data_M,
  output logic [15:0] led_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   ram_q [DEPTH_WORDS];
  logic [15:0]   led_q, led_d;
  logic [31:0]   cyc_q, cyc_d;
  logic          ovf_q, ovf_d, err_q, err_d;
  logic          ram_hit, mmio_hit, rd_req, wr_req;
  mmio_off_e     off;
  logic          push, pop, full, empty;
  logic [TX_CNT_W-1:0] count;
  logic [31:0]   status;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^maddr[1:0];

  assign ram_hit  = (maddr[31:AW+2] == '0);
  assign mmio_hit = (maddr[31:4] == MMIO_BASE[31:4]);
  assign off      = mmio_off_e'(maddr[3:2]);
  // A combined R+W still returns data: the read shows the pre-write value.
  assign rd_req   = DM_CS_M & DM_R_M;
  assign wr_req   = DM_CS_M & DM_W_M;

  assign push     = wr_req & mmio_hit & (off == OFF_TXDATA);
  assign pop      = tx_valid & tx_ready;
  assign tx_valid = ~empty;

  always_comb begin
    status = '0;
    status[STAT_EMPTY] = empty;
    status[STAT_FULL]  = full;
    status[STAT_OVF]   = ovf_q;
    status[STAT_ERR]   = err_q;
    status[STAT_CNT_LSB +: TX_CNT_W] = count;
  end

  always_comb begin
    mr_data_M = '0;
    if (rd_req) begin
      if (ram_hit) mr_data_M = ram_q[maddr[AW+1:2]];
      else if (mmio_hit) begin
        case (off)
          OFF_LED:    mr_data_M = {16'h0, led_q};
          OFF_CYCLE:  mr_data_M = cyc_q;
          OFF_STATUS: mr_data_M = status;
          default:    mr_data_M = '0;
        endcase
      end
    end
  end

  always_comb begin
    led_d = led_q;
    cyc_d = cyc_q + 32'd1;
    ovf_d = ovf_q;
    err_d = err_q;
    if (wr_req & mmio_hit) begin
      case (off)
        OFF_LED:    led_d = mwdata[15:0];
        OFF_CYCLE:  cyc_d = '0;
        OFF_STATUS: begin
          if (mwdata[STAT_OVF]) ovf_d = 1'b0;
          if (mwdata[STAT_ERR]) err_d = 1'b0;
        end
        default: ;
      endcase
    end
    // Sets are applied after clears so a same-cycle set wins.
    if (push & full & ~pop) ovf_d = 1'b1;
    if (DM_CS_M & (DM_R_M | DM_W_M) & ~ram_hit & ~mmio_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= '0;
      cyc_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      led_q <= led_d;
      cyc_q <= cyc_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_req && ram_hit) ram_q[maddr[AW+1:2]] <= mwdata;
  end

  assign led_out = led_q;

  tx_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push & ~reset),
    .wdata_i (mwdata[7:0]),
    .pop_i   (pop),
    .rdata_o (tx_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

endmodule
